exmem_pipe_reg: RTL



---
 rtl/exmem_pipe_reg_if.sv | 56 +++++
 rtl/exmem_pipe_reg.sv | 47 ++++
 2 files changed

// File: rtl/exmem_pipe_reg_if.sv
// EX->MEM pipeline register bundle: EX-side fields, hazard controls and MEM-side outputs.
// The PIPE_PERF_CNT_EN macro adds the CNT_WIDTH parameter and the StallCnt/FlushCnt signals.
interface exmem_pipe_reg_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int RESSRC_WIDTH = 2
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_WIDTH    = 16
`endif
);
  logic                    StallM;
  logic                    FlushM;
  logic                    ValidE;
  logic                    RegWriteE;
  logic                    MemWriteE;
  logic [RESSRC_WIDTH-1:0] ResultSrcE;
  logic [ADDR_WIDTH-1:0]   RdE;
  logic [DATA_WIDTH-1:0]   ALUResultE;
  logic [DATA_WIDTH-1:0]   WriteDataE;
  logic [DATA_WIDTH-1:0]   PCPlus4E;

  logic                    ValidM;
  logic                    RegWriteM;
  logic                    MemWriteM;
  logic [RESSRC_WIDTH-1:0] ResultSrcM;
  logic [ADDR_WIDTH-1:0]   RdM;
  logic [DATA_WIDTH-1:0]   ALUResultM;
  logic [DATA_WIDTH-1:0]   WriteDataM;
  logic [DATA_WIDTH-1:0]   PCPlus4M;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0]    StallCnt;
  logic [CNT_WIDTH-1:0]    FlushCnt;
`endif

  // Handshake: no valid/ready; ValidE qualifies the EX slot, StallM holds and FlushM bubbles MEM.
  modport master (
    output StallM, FlushM, ValidE, RegWriteE, MemWriteE, ResultSrcE, RdE,
           ALUResultE, WriteDataE, PCPlus4E,
`ifdef PIPE_PERF_CNT_EN
    input  StallCnt, FlushCnt,
`endif
    input  ValidM, RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM,
           WriteDataM, PCPlus4M
  );

  modport slave (
    input  StallM, FlushM, ValidE, RegWriteE, MemWriteE, ResultSrcE, RdE,
           ALUResultE, WriteDataE, PCPlus4E,
`ifdef PIPE_PERF_CNT_EN
    output StallCnt, FlushCnt,
`endif
    output ValidM, RegWriteM, MemWriteM, ResultSrcM, RdM, ALUResultM,
           WriteDataM, PCPlus4M
  );
endinterface

// File: rtl/exmem_pipe_reg.sv
// EX->MEM pipeline register with valid tracking, stall hold, flush bubble and write-enable gating.
// Field widths come from the exmem_pipe_reg_if instance; PIPE_PERF_CNT_EN adds saturating counters.
module exmem_pipe_reg (
  input  logic           clk,
  input  logic           rst_n,
  exmem_pipe_reg_if.slave bus
);

  // Flush beats stall; write enables are gated by ValidE so a bubble can never write.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.FlushM) begin
      bus.ValidM     <= 1'b0;
      bus.RegWriteM  <= 1'b0;
      bus.MemWriteM  <= 1'b0;
      bus.ResultSrcM <= '0;
      bus.RdM        <= '0;
      bus.ALUResultM <= '0;
      bus.WriteDataM <= '0;
      bus.PCPlus4M   <= '0;
    end else if (!bus.StallM) begin
      bus.ValidM     <= bus.ValidE;
      bus.RegWriteM  <= bus.RegWriteE & bus.ValidE;
      bus.MemWriteM  <= bus.MemWriteE & bus.ValidE;
      bus.ResultSrcM <= bus.ResultSrcE;
      bus.RdM        <= bus.RdE;
      bus.ALUResultM <= bus.ALUResultE;
      bus.WriteDataM <= bus.WriteDataE;
      bus.PCPlus4M   <= bus.PCPlus4E;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Counters stick at all-ones; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.StallCnt <= '0;
      bus.FlushCnt <= '0;
    end else begin
      if (bus.FlushM && (bus.FlushCnt != '1))
        bus.FlushCnt <= bus.FlushCnt + 1'b1;
      if (bus.StallM && !bus.FlushM && (bus.StallCnt != '1))
        bus.StallCnt <= bus.StallCnt + 1'b1;
    end
  end
`endif

endmodule
